// File: rtl/neuron_accumulator.sv
// Neuron pre-activation: bias + sum(x*w) in Q4.12, full-precision accumulate, rescale and saturate.
// Optional build macro NEURON_ACC_ROUND_EN selects round-half-up instead of floor on rescale.
module neuron_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 12,
    parameter int ACC_W    = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] in_bias,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_x
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef NEURON_ACC_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`endif

    logic [1:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                      beat;
    logic                      close;

    // Drop the fractional bits of the Q.24 accumulator back to Q.12.
    function automatic logic signed [ACC_W-1:0] rescale(input logic signed [ACC_W-1:0] a);
`ifdef NEURON_ACC_ROUND_EN
        return (a + HALF) >>> FRAC_W;
`else
        return a >>> FRAC_W;
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] r);
        if (r > SAT_MAX)
            return OUT_MAX;
        else if (r < SAT_MIN)
            return OUT_MIN;
        return r[DATA_W-1:0];
    endfunction

    assign prod     = in_x * in_w;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){in_bias[DATA_W-1]}}, in_bias} <<< FRAC_W;

    assign in_ready = !rst && (state != HOLD);
    assign beat     = in_valid && in_ready;

    // Bias enters the sum only on the opening beat of a vector.
    assign acc_nxt = (state == IDLE) ? (bias_ext + prod_ext) : (acc + prod_ext);
    assign close   = in_last || ((state == IDLE) ? (N_INPUTS == 1)
                                                 : (cnt == CNT_W'(N_INPUTS - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc <= acc_nxt;
                        cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
                        if (close) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_x     <= saturate(rescale(acc_nxt));
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: vector-level reference model plus directed vectors with literal results.
module tb_neuron_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic [15:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;

    int n_checks = 0;
    int n_err    = 0;
    bit armed    = 0;

    // reference model state
    bit          m_hold;
    int          m_cnt;
    longint      m_sum;
    logic [15:0] exp_x;

    neuron_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Expected Q4.12 output from an exact Q8.24 sum.
    function automatic logic [15:0] model_out(input longint s);
        longint r;
`ifdef NEURON_ACC_ROUND_EN
        r = (s + 2048) >>> 12;
`else
        r = s >>> 12;
`endif
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 0;
            m_cnt  = 0;
            m_sum  = 0;
            exp_x  = 16'h0000;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            if (m_cnt == 0) m_sum = longint'($signed(in_bias)) * 4096;
            m_sum = m_sum + longint'($signed(in_x)) * longint'($signed(in_w));
            m_cnt++;
            if (in_last || m_cnt == 8) begin
                m_hold = 1;
                m_cnt  = 0;
                exp_x  = model_out(m_sum);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (rst) begin
                check("rst_in_ready", {15'd0, in_ready}, 16'd0);
                check("rst_out_valid", {15'd0, out_valid}, 16'd0);
                check("rst_out_x", out_x, 16'h0000);
            end else begin
                check("in_ready", {15'd0, in_ready}, {15'd0, !m_hold});
                check("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
                if (m_hold) check("out_x", out_x, exp_x);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] b, input logic [15:0] x, input logic [15:0] w, input logic l);
        int g;
        in_valid = 1; in_bias = b; in_x = x; in_w = w; in_last = l;
        g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) fail("send");
        tick();
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic wait_out(input string name, input logic [15:0] lit);
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) fail(name);
        else check(name, out_x, lit);
    endtask

    task automatic pop();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        logic [15:0] lit;
        rst = 0; in_valid = 0; in_x = 0; in_w = 0; in_bias = 0; in_last = 0; out_ready = 0;
        #2;
        rst   = 1;
        armed = 1;
        repeat (3) tick();
        rst = 0;
        tick();

        // 1: bias 0.5 + 3 x (1.0*2.0) = 6.5
        send(16'h0800, 16'h1000, 16'h2000, 0);
        send(16'h0000, 16'h1000, 16'h2000, 0);
        send(16'h0000, 16'h1000, 16'h2000, 1);
        check("t1_latency", {15'd0, out_valid}, 16'd1);
        wait_out("t1_out", 16'h6800);
        pop();

        // 2: positive and negative saturation
        for (int i = 0; i < 4; i++) send(16'h0000, 16'h7FFF, 16'h7FFF, i == 3);
        wait_out("t2_pos_sat", 16'h7FFF);
        pop();
        for (int i = 0; i < 4; i++) send(16'h0000, 16'h7FFF, 16'h8000, i == 3);
        wait_out("t2_neg_sat", 16'h8000);
        pop();

        // 3: rescale of tiny values
        send(16'h0000, 16'h0001, 16'h0800, 1);
`ifdef NEURON_ACC_ROUND_EN
        lit = 16'h0001;
`else
        lit = 16'h0000;
`endif
        wait_out("t3_pos_half", lit);
        pop();
        send(16'h0000, 16'hFFFF, 16'h0800, 1);
`ifdef NEURON_ACC_ROUND_EN
        lit = 16'h0000;
`else
        lit = 16'hFFFF;
`endif
        wait_out("t3_neg_half", lit);
        pop();

        // 4: vector closes at beat 8 without in_last; a 9th beat waits
        for (int i = 0; i < 8; i++) send(16'h0000, 16'h1000, 16'h0200, 0);
        wait_out("t4_out", 16'h1000);
        in_valid = 1; in_bias = 16'h0000; in_x = 16'h1000; in_w = 16'h1000; in_last = 1;
        repeat (3) begin
            tick();
            check("t4_ninth_wait", {15'd0, in_ready}, 16'd0);
        end
        pop();
        send(16'h0000, 16'h1000, 16'h1000, 1);
        wait_out("t4_ninth_out", 16'h1000);
        pop();

        // 5: held output under back-pressure, beat accepted right after the handshake
        send(16'h0000, 16'h1000, 16'h0800, 0);
        send(16'h0000, 16'h1000, 16'h0800, 1);
        wait_out("t5_out", 16'h1000);
        repeat (5) begin
            tick();
            check("t5_stable_x", out_x, 16'h1000);
            check("t5_stable_rdy", {15'd0, in_ready}, 16'd0);
        end
        in_valid = 1; in_bias = 16'h1000; in_x = 16'h2000; in_w = 16'h1000; in_last = 1;
        pop();
        check("t5_ready_after", {15'd0, in_ready}, 16'd1);
        send(16'h1000, 16'h2000, 16'h1000, 1);
        wait_out("t5_next", 16'h3000);
        pop();

        // 6: reset mid-vector discards the partial sum
        send(16'h7000, 16'h1000, 16'h1000, 0);
        send(16'h0000, 16'h1000, 16'h1000, 0);
        rst = 1;
        tick();
        check("t6_rst_valid", {15'd0, out_valid}, 16'd0);
        rst = 0;
        tick();
        send(16'h0000, 16'h1000, 16'h1000, 1);
        wait_out("t6_out", 16'h1000);
        pop();

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
